// File: rtl/ex_mdu_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op codes, latencies,
// FSM states and the arithmetic helper that produces HI/LO results.
package ex_mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  localparam int unsigned MDU_MULT_CYCLES = 5;
  localparam int unsigned MDU_DIV_CYCLES  = 10;

  typedef enum logic [0:0] {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_e;

  // wr=0 means the result must not touch HI/LO (divide by zero)
  typedef struct packed {
    logic        wr;
    logic [31:0] hi;
    logic [31:0] lo;
  } mdu_res_t;

  function automatic mdu_res_t mdu_calc(input logic [3:0]  op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    mdu_res_t res;
    res = '0;
    case (op)
      MDU_MULT: begin
        res.wr = 1'b1;
        {res.hi, res.lo} = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
      end
      MDU_MULTU: begin
        res.wr = 1'b1;
        {res.hi, res.lo} = 64'({32'd0, a} * {32'd0, b});
      end
      MDU_DIV: begin
        if (b != 32'd0) begin
          res.wr = 1'b1;
          res.lo = 32'($signed({{32{a[31]}}, a}) / $signed({{32{b[31]}}, b}));
          res.hi = 32'($signed({{32{a[31]}}, a}) % $signed({{32{b[31]}}, b}));
        end else begin
          res.wr = 1'b0;
        end
      end
      MDU_DIVU: begin
        if (b != 32'd0) begin
          res.wr = 1'b1;
          res.lo = a / b;
          res.hi = a % b;
        end else begin
          res.wr = 1'b0;
        end
      end
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ex_mdu.sv
// EX-stage multiply/divide unit: architectural HI/LO, fixed-latency MULT/DIV
// sequencing, single-cycle MTHI/MTLO and combinational MFHI/MFLO read path.
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [3:0]  mdu_op,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] mdu_out
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  mdu_state_e  state_r;
  mdu_state_e  state_s;
  logic [3:0]  cnt_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  mdu_res_t    pend_r;
  mdu_res_t    calc_s;
  logic        issue_s;
  logic        is_div_s;
  logic        mthi_s;
  logic        mtlo_s;
  logic [3:0]  load_cnt_s;

  // Issue decode: only an un-flushed op in IDLE may act
  always_comb begin
    issue_s  = 1'b0;
    is_div_s = 1'b0;
    mthi_s   = 1'b0;
    mtlo_s   = 1'b0;
    if ((state_r == MDU_IDLE) && !req) begin
      case (mdu_op)
        MDU_MULT, MDU_MULTU: issue_s = start;
        MDU_DIV, MDU_DIVU: begin
          issue_s  = start;
          is_div_s = 1'b1;
        end
        MDU_MTHI: mthi_s = 1'b1;
        MDU_MTLO: mtlo_s = 1'b1;
        default: issue_s = 1'b0;
      endcase
    end else begin
      issue_s = 1'b0;
    end
    calc_s     = mdu_calc(mdu_op, A, B);
    load_cnt_s = is_div_s ? DIV_CNT : MULT_CNT;
  end

  // Next-state logic; req has no influence once RUN is entered
  always_comb begin
    state_s = state_r;
    case (state_r)
      MDU_IDLE: begin
        if (issue_s) begin
          state_s = MDU_RUN;
        end else begin
          state_s = MDU_IDLE;
        end
      end
      MDU_RUN: begin
        if (cnt_r == 4'd1) begin
          state_s = MDU_IDLE;
        end else begin
          state_s = MDU_RUN;
        end
      end
      default: state_s = MDU_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= MDU_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Latency counter and pending result captured at the start edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r  <= 4'd0;
      pend_r <= '0;
    end else if (issue_s) begin
      cnt_r  <= load_cnt_s;
      pend_r <= calc_s;
    end else if (state_r == MDU_RUN) begin
      cnt_r <= cnt_r - 4'd1;
    end
  end

  // Architectural HI/LO: committed result or direct MTHI/MTLO write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else if ((state_r == MDU_RUN) && (cnt_r == 4'd1)) begin
      if (pend_r.wr) begin
        hi_r <= pend_r.hi;
        lo_r <= pend_r.lo;
      end
    end else if (mthi_s) begin
      hi_r <= A;
    end else if (mtlo_s) begin
      lo_r <= A;
    end
  end

  // MFHI/MFLO read path sees only committed HI/LO
  always_comb begin
    mdu_out = 32'd0;
    case (mdu_op)
      MDU_MFHI: mdu_out = hi_r;
      MDU_MFLO: mdu_out = lo_r;
      default:  mdu_out = 32'd0;
    endcase
  end

  assign busy = (state_r == MDU_RUN);
  assign HI   = hi_r;
  assign LO   = lo_r;

endmodule

// File: tb/tb_ex_mdu.sv
// Scoreboard bench for ex_mdu: stimulus pushes model results into a queue, a
// negedge monitor pops and compares when busy falls; directed and random ops.
module tb_ex_mdu;
  import ex_mdu_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic [3:0]  mdu_op = 4'd0;
  logic        start = 1'b0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] mdu_out;

  ex_mdu dut (
    .clk(clk), .reset(reset), .req(req), .mdu_op(mdu_op), .start(start),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO), .mdu_out(mdu_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: architectural meaning of each op in plain 64-bit arithmetic
  function automatic void ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 inout logic [31:0] hi, inout logic [31:0] lo);
    longint          p, q, r;
    longint unsigned up, ua, ub;
    ua = a;
    ub = b;
    case (op)
      MDU_MULT: begin
        p  = longint'($signed(a)) * longint'($signed(b));
        hi = p[63:32];
        lo = p[31:0];
      end
      MDU_MULTU: begin
        up = ua * ub;
        hi = up[63:32];
        lo = up[31:0];
      end
      MDU_DIV: if (b != 0) begin
        q  = longint'($signed(a)) / longint'($signed(b));
        r  = longint'($signed(a)) - q * longint'($signed(b));
        lo = q[31:0];
        hi = r[31:0];
      end
      MDU_DIVU: if (b != 0) begin
        lo = a / b;
        hi = a - (a / b) * b;
      end
      default: ;
    endcase
  endfunction

  // Monitor: measure busy length, compare against queued expectation on falling busy
  int   run_len = 0;
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      run_len   = 0;
      prev_busy = 1'b0;
    end else begin
      if (busy && (start || mdu_op == MDU_MTHI || mdu_op == MDU_MTLO)) begin
        errors++;
        $display("FAIL illegal_issue actual=%0d expected=0", 1);
      end
      if (busy) run_len++;
      if (prev_busy && !busy) begin
        if (sb_q.size() == 0) begin
          chk("mon_unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("mon_hi", HI, e.hi);
          chk("mon_lo", LO, e.lo);
          chk("mon_busy_len", 32'(run_len), 32'(e.len));
        end
        run_len = 0;
      end
      prev_busy = busy;
    end
  end

  task automatic issue_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic req_v);
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1; mdu_op = op; A = a; B = b; req = req_v;
    @(posedge clk); #1;
    start = 1'b0; mdu_op = MDU_NONE; req = 1'b0;
    if (!req_v) begin
      ref_op(op, a, b, hi_m, lo_m);
      e.hi  = hi_m;
      e.lo  = lo_m;
      e.len = (op == MDU_DIV || op == MDU_DIVU) ? DIV_N : MULT_N;
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      if (sb_q.size() == 0) break;
      @(posedge clk);
    end
    #1;
    if (sb_q.size() != 0) begin
      chk("done_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  task automatic do_mt(input logic [3:0] op, input logic [31:0] a, input logic req_v);
    @(posedge clk); #1;
    mdu_op = op; A = a; req = req_v;
    @(posedge clk); #1;
    mdu_op = MDU_NONE; req = 1'b0;
    if (!req_v) begin
      if (op == MDU_MTHI) hi_m = a;
      else lo_m = a;
    end
    chk("mt_busy", {31'd0, busy}, 32'd0);
    chk("mt_hi", HI, hi_m);
    chk("mt_lo", LO, lo_m);
  endtask

  task automatic read_check();
    mdu_op = MDU_MFHI; #1;
    chk("mfhi", mdu_out, hi_m);
    mdu_op = MDU_MFLO; #1;
    chk("mflo", mdu_out, lo_m);
    mdu_op = MDU_NONE; #1;
    chk("mf_none", mdu_out, 32'd0);
  endtask

  function automatic logic [31:0] rnd_val();
    logic [31:0] specials [4];
    specials[0] = 32'h8000_0000;
    specials[1] = 32'hFFFF_FFFF;
    specials[2] = 32'd0;
    specials[3] = 32'd1;
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 3)];
    return $urandom();
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    reset = 1'b1;

    // MULT -2 x 3
    issue_md(MDU_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    wait_done();
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFFA);
    read_check();

    issue_md(MDU_DIVU, 32'hFFFF_FFFF, 32'h10, 1'b0);
    wait_done();
    chk("divu_lo", LO, 32'h0FFF_FFFF);
    chk("divu_hi", HI, 32'h0000_000F);

    issue_md(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_done();
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);

    do_mt(MDU_MTHI, 32'h1234, 1'b0);
    chk("mthi_val", HI, 32'h1234);
    read_check();

    // Divide by zero keeps HI/LO
    issue_md(MDU_DIV, 32'd99, 32'd0, 1'b0);
    wait_done();
    chk("div0_hi", HI, 32'h1234);
    chk("div0_lo", LO, 32'hFFFF_FFFD);

    // Flushed start and flushed MTLO are dropped
    issue_md(MDU_MULT, 32'd5, 32'd5, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_hi", HI, hi_m);
    chk("flush_lo", LO, lo_m);
    do_mt(MDU_MTLO, 32'hDEAD_BEEF, 1'b1);
    chk("flush_mtlo", LO, 32'hFFFF_FFFD);

    // req during RUN does not cancel
    issue_md(MDU_MULT, 32'd3, 32'd4, 1'b0);
    @(posedge clk); #1;
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    wait_done();
    chk("req_run_lo", LO, 32'd12);

    // Asynchronous reset in the middle of a DIV
    issue_md(MDU_DIV, 32'd1000, 32'd7, 1'b0);
    @(posedge clk); @(posedge clk);
    sb_q.delete();
    #2;
    reset = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", HI, 32'd0);
    chk("arst_lo", LO, 32'd0);
    hi_m = 32'd0;
    lo_m = 32'd0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    issue_md(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_done();
    chk("multu_hi", HI, 32'd1);
    chk("multu_lo", LO, 32'hFFFF_FFFE);

    // Random mix checked against the reference model
    for (int n = 0; n < 24; n++) begin
      int sel;
      logic [31:0] a, b;
      sel = $urandom_range(0, 5);
      a = rnd_val();
      b = ($urandom_range(0, 4) == 0) ? 32'd0 : rnd_val();
      if (sel < 4) begin
        issue_md(4'(sel + 1), a, b, 1'b0);
        wait_done();
      end else begin
        do_mt((sel == 4) ? MDU_MTHI : MDU_MTLO, a, 1'b0);
      end
      read_check();
    end

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mdu.md
Name: ex_mdu

Overview:
- Multiply/divide unit for the EX stage of the 5-stage MIPS pipeline; sits beside the ALU and feeds the EX->MEM pipeline register.
- Holds the architectural HI/LO registers and executes MULT/MULTU/DIV/DIVU with fixed multi-cycle latency.
- Executes MTHI/MTLO in one cycle and supplies MFHI/MFLO data on the EX result path.
- Exports busy/start status so the hazard unit can stall later MDU instructions in ID.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15).

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  exception/interrupt flush request from CP0; the instruction currently in EX is being cancelled.
- mdu_op  in  4  operation code from the EX control decode (MDU_* constants).
- start  in  1  high for one cycle when a MULT/MULTU/DIV/DIVU is in EX.
- A  in  32  rs operand, already forwarded.
- B  in  32  rt operand, already forwarded.
- busy  out  1  multi-cycle operation in progress.
- HI  out  32  architectural HI.
- LO  out  32  architectural LO.
- mdu_out  out  32  MFHI -> HI, MFLO -> LO, otherwise 0 (combinational).

Behaviour:
- Reset (reset=0, asynchronous):
  - HI, LO, pending registers and counter all clear to 0.
  - State goes to IDLE; busy=0.
- States:
  - IDLE: busy=0.
  - RUN: busy=1; cnt is a 4-bit down-counter.
- IDLE, start=1, req=0:
  - Compute the product or quotient/remainder from A and B at the start edge and latch it into pend_hi/pend_lo.
  - Load cnt = MULT_CYCLES or DIV_CYCLES; go to RUN. busy rises the cycle after start.
- RUN:
  - cnt decrements on each edge.
  - On the edge where cnt==1: commit HI<=pend_hi, LO<=pend_lo, go to IDLE.
  - busy is therefore high for exactly N cycles, and HI/LO show the new values in the first cycle busy=0.
- Arithmetic:
  - MULT: signed 32x32->64; HI=upper 32 bits, LO=lower 32 bits.
  - MULTU: unsigned 32x32->64, same split.
  - DIV: signed; LO=quotient truncated toward zero; HI=remainder carrying the sign of the dividend (-7/2 -> LO=-3, HI=-1).
  - DIVU: unsigned.
- Divide by zero (B==0): the operation still occupies DIV_CYCLES; HI/LO are left unchanged at commit.
- MTHI / MTLO (mdu_op, req=0, state IDLE): HI<=A or LO<=A on the next edge; no busy cycle.
- req=1 in the same cycle as start or MTHI/MTLO: the op is discarded; HI/LO, state and counter do not change.
- req=1 during RUN: no effect. The running op belongs to an older instruction that has already committed, so it completes normally.
- Illegal issue:
  - start, MTHI or MTLO arriving while busy=1 is ignored.
  - The hazard unit guarantees this never happens: ID stalls any MDU instruction while busy|start.
  - The bench flags it as an error.
- mdu_out: pure combinational read of the current HI/LO; no write-through from a same-cycle MTHI/MTLO.
- start with a non-multiply/divide mdu_op: ignored.

Decomposition:
- const.v gains the `MDU_MULT, `MDU_MULTU, `MDU_DIV, `MDU_DIVU, `MDU_MFHI, `MDU_MFLO, `MDU_MTHI, `MDU_MTLO 4-bit codes (0 = MDU_NONE).
- const.v also gains the default latencies.
- No sub-module: the counter/FSM and the result latch live in ex_mdu.
- Arithmetic uses the native * and / / % operators on 64-bit signed/unsigned casts.

Test Plan:
- MULT A=0xFFFFFFFE (-2), B=3 -> busy high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MFLO gives mdu_out=0xFFFFFFFA.
- DIVU A=0xFFFFFFFF, B=0x10 -> busy for 10 cycles; then LO=0x0FFFFFFF, HI=0x0000000F. DIV A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- MTHI A=0x1234 then MFHI -> HI=0x1234 one edge later, busy never asserts. Then DIV with B=0 -> 10 busy cycles, HI=0x1234 unchanged.
- start=1 with req=1 (MULT 5x5) -> busy stays 0, HI/LO keep their prior values. Same check for MTLO with req=1: LO unchanged.
- MULT 3x4 started; req pulses in cycle 2 of RUN -> completes at cycle 5 with LO=12.
- reset driven low at cycle 3 of a DIV -> immediate busy=0, HI=LO=0. After release, a new MULTU 0xFFFFFFFF x 2 gives HI=1, LO=0xFFFFFFFE.
